// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage.
// Issues one registered SRAM request per load/store, stalls the upstream
// pipeline until the controller pulses ready, then loads the MEM/WB register
// that feeds the register file.
module mem_wb_stage #(
  parameter int unsigned DATA_BASE = 1024,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [31:0]       alu_res,
  input  logic [31:0]       st_val,
  input  logic [3:0]        dest,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  input  logic              sram_ready,
  output logic              freeze,
  output logic [31:0]       Result_WB,
  output logic [3:0]        Dest_wb,
  output logic              writeBackEn
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e              state_q, state_d;
  logic                mem_op;
  logic [31:0]         byte_off;

  logic                sram_req_q, sram_req_d;
  logic                sram_we_q, sram_we_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [31:0]         sram_wdata_q, sram_wdata_d;

  logic [31:0]         result_q, result_d;
  logic [3:0]          dest_q, dest_d;
  logic                wben_q, wben_d;

  assign mem_op   = mem_r_en | mem_w_en;
  // Offset into the data region; addresses below the base wrap around.
  assign byte_off = alu_res - 32'(DATA_BASE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state: leave IDLE on a memory op, leave BUSY on the ready pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_op)     state_d = BUSY;
      BUSY:    if (sram_ready) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Outputs: stall, request next-state and MEM/WB next-state.
  always_comb begin
    // Stall every cycle of a memory op except the one in which it completes.
    freeze       = mem_op & ~((state_q == BUSY) & sram_ready);

    sram_req_d   = sram_req_q;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    if (state_q == IDLE && mem_op) begin
      // Inputs are held by upstream while frozen, so sample them only here.
      sram_req_d   = 1'b1;
      sram_we_d    = mem_w_en & ~mem_r_en;    // load wins if both are set
      sram_addr_d  = ADDR_W'(byte_off >> 2);  // byte -> word, drop [1:0]
      sram_wdata_d = st_val;
    end else if (state_q == BUSY && sram_ready) begin
      sram_req_d   = 1'b0;
    end

    result_d = result_q;
    dest_d   = dest_q;
    wben_d   = 1'b0;                          // bubble while frozen
    if (!freeze) begin
      result_d = mem_r_en ? sram_rdata : alu_res;
      dest_d   = dest;
      wben_d   = wb_en_in;
    end
  end

  // SRAM request registers; reset drops an outstanding request immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_req_q   <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      sram_req_q   <= sram_req_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
      dest_q   <= '0;
      wben_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      dest_q   <= dest_d;
      wben_q   <= wben_d;
    end
  end

  assign sram_req    = sram_req_q;
  assign sram_we     = sram_we_q;
  assign sram_addr   = sram_addr_q;
  assign sram_wdata  = sram_wdata_q;
  assign Result_WB   = result_q;
  assign Dest_wb     = dest_q;
  assign writeBackEn = wben_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: stimulus pushes expected SRAM requests
// and write-backs; monitors pop and compare whenever the DUT presents them.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en, mem_w_en;
  logic [31:0] alu_res, st_val;
  logic [3:0]  dest;
  logic        sram_req, sram_we;
  logic [15:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic        sram_ready;
  logic        freeze;
  logic [31:0] Result_WB;
  logic [3:0]  Dest_wb;
  logic        writeBackEn;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  dst;
  } wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];
  req_t cur_req;
  logic req_active = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_wb_stage #(.DATA_BASE(1024), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_res(alu_res), .st_val(st_val), .dest(dest),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .freeze(freeze), .Result_WB(Result_WB), .Dest_wb(Dest_wb),
    .writeBackEn(writeBackEn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wb, input logic r, input logic w,
                       input logic [31:0] alu, input logic [31:0] st, input logic [3:0] d);
    wb_en_in = wb; mem_r_en = r; mem_w_en = w;
    alu_res = alu; st_val = st; dest = d;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
  endtask

  // Called just after a rising edge; ends just after the capturing edge.
  task automatic alu_op(input logic wb, input logic [31:0] alu, input logic [3:0] d);
    wb_t e;
    drive(wb, 1'b0, 1'b0, alu, 32'h0, d);
    if (wb) begin e.res = alu; e.dst = d; wb_q.push_back(e); end
    @(negedge clk);
    chk("alu_freeze", {31'b0, freeze}, 32'd0);
    chk("alu_req", {31'b0, sram_req}, 32'd0);
    @(posedge clk); #1;
    nop();
    chk("alu_wben", {31'b0, writeBackEn}, {31'b0, wb});
    chk("alu_result", Result_WB, alu);
    chk("alu_dest", {28'b0, Dest_wb}, {28'b0, d});
  endtask

  // Memory op with `waits` BUSY cycles before the ready pulse.
  task automatic mem_op(input logic wb, input logic r, input logic w,
                        input logic [31:0] alu, input logic [31:0] st, input logic [3:0] d,
                        input int waits, input logic [31:0] rdata, input logic [15:0] exp_addr);
    req_t rq;
    wb_t  e;
    int   nfreeze = 0;
    logic [31:0] exp_res;
    exp_res = r ? rdata : alu;
    drive(wb, r, w, alu, st, d);
    rq.we = w & ~r; rq.addr = exp_addr; rq.wdata = st;
    req_q.push_back(rq);
    if (wb) begin e.res = exp_res; e.dst = d; wb_q.push_back(e); end
    @(negedge clk);
    if (freeze) nfreeze++;
    chk("idle_req", {31'b0, sram_req}, 32'd0);
    for (int i = 0; i <= waits; i++) begin
      @(posedge clk); #1;
      if (i == waits) begin sram_ready = 1'b1; sram_rdata = rdata; end
      else            sram_rdata = 32'hFFFF0000;
      @(negedge clk);
      if (freeze) nfreeze++;
      chk("busy_req", {31'b0, sram_req}, 32'd1);
    end
    @(posedge clk); #1;
    sram_ready = 1'b0; sram_rdata = 32'h0;
    nop();
    chk("freeze_cycles", 32'(nfreeze), 32'(waits + 1));
    chk("mem_wben", {31'b0, writeBackEn}, {31'b0, wb});
    chk("mem_result", Result_WB, exp_res);
    chk("mem_req_done", {31'b0, sram_req}, 32'd0);
  endtask

  // SRAM request monitor: one expected entry per request; held while high.
  always @(negedge clk) begin
    if (!rst) req_active = 1'b0;
    else if (sram_req) begin
      if (!req_active) begin
        if (req_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL req_unexpected: got addr %h we %b, expected no request", sram_addr, sram_we);
        end else begin
          cur_req = req_q.pop_front();
        end
        req_active = 1'b1;
      end
      chk("req_we", {31'b0, sram_we}, {31'b0, cur_req.we});
      chk("req_addr", {16'b0, sram_addr}, {16'b0, cur_req.addr});
      chk("req_wdata", sram_wdata, cur_req.wdata);
    end else req_active = 1'b0;
  end

  // Write-back monitor.
  always @(negedge clk) begin
    if (rst && writeBackEn) begin
      if (wb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wb_unexpected: got res %h dest %0d, expected no write-back", Result_WB, Dest_wb);
      end else begin
        wb_t e;
        e = wb_q.pop_front();
        chk("wb_result", Result_WB, e.res);
        chk("wb_dest", {28'b0, Dest_wb}, {28'b0, e.dst});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    sram_ready = 1'b0; sram_rdata = 32'h0;
    drive(1'b1, 1'b1, 1'b0, 32'd1028, 32'h1, 4'd1);
    #3;
    chk("rst_req", {31'b0, sram_req}, 32'd0);
    chk("rst_addr", {16'b0, sram_addr}, 32'd0);
    chk("rst_wben", {31'b0, writeBackEn}, 32'd0);
    chk("rst_result", Result_WB, 32'd0);
    chk("rst_freeze_memop", {31'b0, freeze}, 32'd1);
    nop();
    #1;
    chk("rst_freeze_nop", {31'b0, freeze}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Plain ALU ops.
    alu_op(1'b1, 32'h0000_1234, 4'd5);
    alu_op(1'b1, 32'hFFFF_FFFF, 4'd15);

    // Load with ready in the 3rd BUSY cycle.
    mem_op(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd3, 2, 32'hDEADBEEF, 16'd1);
    // Store, no write-back, ready in 1st BUSY cycle.
    mem_op(1'b0, 1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 4'd4, 0, 32'hBAD0BAD0, 16'd2);
    // Two back-to-back loads with immediate ready.
    mem_op(1'b1, 1'b1, 1'b0, 32'd1100, 32'h0, 4'd6, 0, 32'h1111_2222, 16'd19);
    mem_op(1'b1, 1'b1, 1'b0, 32'd1104, 32'h0, 4'd8, 0, 32'h3333_4444, 16'd20);
    // Address below base wraps, then truncates.
    mem_op(1'b1, 1'b1, 1'b0, 32'd0, 32'h0, 4'd2, 1, 32'h0BAD_F00D, 16'hFF00);
    // Both enables set: treated as a load.
    mem_op(1'b1, 1'b1, 1'b1, 32'd1036, 32'h7777_7777, 4'd10, 0, 32'h1357_9BDF, 16'd3);
    // Writeback-form store at a misaligned address: result is the address.
    mem_op(1'b1, 1'b0, 1'b1, 32'd1031, 32'h0000_0011, 4'd9, 1, 32'hBAD0BAD0, 16'd1);

    // Reset while BUSY; the later ready pulse must be ignored.
    begin
      req_t rq;
      drive(1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 4'd7);
      rq.we = 1'b0; rq.addr = 16'd4; rq.wdata = 32'h0;
      req_q.push_back(rq);
    end
    @(negedge clk);
    chk("rb_idle_req", {31'b0, sram_req}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rb_busy_req", {31'b0, sram_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rb_req", {31'b0, sram_req}, 32'd0);
    chk("rb_addr", {16'b0, sram_addr}, 32'd0);
    chk("rb_wdata", sram_wdata, 32'd0);
    chk("rb_result", Result_WB, 32'd0);
    chk("rb_dest", {28'b0, Dest_wb}, 32'd0);
    chk("rb_freeze", {31'b0, freeze}, 32'd1);
    nop();
    #1;
    chk("rb_freeze_nop", {31'b0, freeze}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    sram_ready = 1'b1; sram_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("rb_ready_req", {31'b0, sram_req}, 32'd0);
    chk("rb_ready_freeze", {31'b0, freeze}, 32'd0);
    @(posedge clk); #1;
    sram_ready = 1'b0;
    chk("rb_no_wb", {31'b0, writeBackEn}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rb_still_idle", {31'b0, sram_req}, 32'd0);

    chk("req_queue_empty", 32'(req_q.size()), 32'd0);
    chk("wb_queue_empty", 32'(wb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
